// File: rtl/register_pkg.sv
// Shared register-file types: physical tag type, free-list sizing and the
// wrap-bit pointer type used by the physical register free list.
package register_pkg;

  localparam int unsigned NUM_PREGS       = 64;
  localparam int unsigned NUM_AREGS       = 32;
  localparam int unsigned FREE_LIST_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned PREG_W          = $clog2(NUM_PREGS);
  localparam int unsigned FL_IDX_W        = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned FL_PTR_W        = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0] physical_reg_t;

  typedef struct packed {
    logic                wrap;
    logic [FL_IDX_W-1:0] idx;
  } fl_ptr_t;

  function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
    return fl_ptr_t'({p.wrap, p.idx} + FL_PTR_W'(1));
  endfunction

  // Occupancy between two pointers, modulo 2^FL_PTR_W.
  function automatic logic [FL_PTR_W-1:0] fl_count(input fl_ptr_t tail, input fl_ptr_t head);
    return FL_PTR_W'({tail.wrap, tail.idx} - {head.wrap, head.idx});
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags feeding rename; commit returns
// stale tags, flush restores the speculative head. Optional: FREE_LIST_BYPASS_EN.
module phys_reg_free_list
  import register_pkg::*;
#(
  parameter bit CHECK_NO_OVERFLOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output physical_reg_t       alloc_preg,
  input  logic                commit_valid,
  input  logic                release_valid,
  input  physical_reg_t       release_preg,
  input  logic                flush,
  output logic [FL_PTR_W-1:0] free_count,
  output logic                err_overflow
);

  physical_reg_t entry_q [FREE_LIST_DEPTH];
  fl_ptr_t       head_q, tail_q, commit_head_q;
  fl_ptr_t       head_d, tail_d, commit_head_d;
  logic          err_d;
  logic          empty, full, rel_ok, bypass, do_alloc, wr_en, commit_ok, commit_bad;

  // Next-state and combinational outputs from registered pointers.
  always_comb begin
    empty      = (head_q == tail_q);
    full       = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);
    rel_ok     = release_valid && (release_preg != '0);
`ifdef FREE_LIST_BYPASS_EN
    bypass     = empty && rel_ok && !flush;
`else
    bypass     = 1'b0;
`endif
    alloc_valid = !empty || bypass;
    alloc_preg  = bypass ? release_preg : entry_q[head_q.idx];
    free_count  = fl_count(tail_q, head_q);

    do_alloc   = alloc_req && alloc_valid && !flush;
    wr_en      = rel_ok && !full;
    commit_bad = commit_valid && (commit_head_q == head_q);
    commit_ok  = commit_valid && !commit_bad;

    tail_d        = wr_en     ? fl_ptr_inc(tail_q)        : tail_q;
    commit_head_d = commit_ok ? fl_ptr_inc(commit_head_q) : commit_head_q;
    if (flush) begin
      head_d = commit_head_d;
    end else if (do_alloc) begin
      head_d = fl_ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    err_d = err_overflow || (rel_ok && full) || commit_bad;
  end

  // Pointer and sticky error registers; tail starts one lap ahead (list full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '{wrap: 1'b1, idx: '0};
      commit_head_q <= '0;
      err_overflow  <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      commit_head_q <= commit_head_d;
      err_overflow  <= err_d;
    end
  end

  // Tag storage; at reset holds every unmapped physical register in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
        entry_q[i] <= physical_reg_t'(NUM_AREGS + i);
      end
    end else if (wr_en) begin
      entry_q[tail_q.idx] <= release_preg;
    end
  end

`ifndef SYNTHESIS
  function automatic logic slot_live(input int unsigned k, input fl_ptr_t h,
                                     input logic [FL_PTR_W-1:0] cnt);
    logic [FL_IDX_W-1:0] off;
    off = FL_IDX_W'(k) - h.idx;
    return ({1'b0, off} < cnt);
  endfunction

  logic dup_live;

  always_comb begin
    dup_live = 1'b0;
    for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
      for (int unsigned j = i + 1; j < FREE_LIST_DEPTH; j++) begin
        if (slot_live(i, head_q, free_count) && slot_live(j, head_q, free_count) &&
            (entry_q[i] == entry_q[j])) begin
          dup_live = 1'b1;
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    free_count <= FL_PTR_W'(FREE_LIST_DEPTH));

  a_no_dup_tag: assert property (@(posedge clk) disable iff (!rst_n) !dup_live);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || !CHECK_NO_OVERFLOW)
    !err_overflow);
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Vector-table bench for phys_reg_free_list; expected outputs are queued as
// each vector is driven and compared mid-cycle before the consuming edge.
module tb_phys_reg_free_list;
  import register_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_req, alloc_valid, commit_valid, release_valid, flush, err_overflow;
  physical_reg_t alloc_preg, release_preg;
  logic [5:0]    free_count;

  phys_reg_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .commit_valid(commit_valid), .release_valid(release_valid), .release_preg(release_preg),
    .flush(flush), .free_count(free_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          alloc_req;
    logic          commit_valid;
    logic          release_valid;
    physical_reg_t release_preg;
    logic          flush;
    logic          exp_valid;
    physical_reg_t exp_preg;
    logic [5:0]    exp_count;
    logic          exp_err;
  } vec_t;

  vec_t  vecs[$];
  vec_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d required %0d", phase, name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic c, input logic r, input int rp,
                              input logic f, input logic ev, input int ep, input int ec,
                              input logic ee);
    vec_t v;
    v.alloc_req = a; v.commit_valid = c; v.release_valid = r;
    v.release_preg = physical_reg_t'(rp); v.flush = f;
    v.exp_valid = ev; v.exp_preg = physical_reg_t'(ep);
    v.exp_count = 6'(ec); v.exp_err = ee;
    return v;
  endfunction

  // Observe-only cycle, and a plain allocate cycle.
  function automatic vec_t idle(input logic ev, input int ep, input int ec, input logic ee);
    return mk(1'b0, 1'b0, 1'b0, 0, 1'b0, ev, ep, ec, ee);
  endfunction

  function automatic vec_t alloc(input int ep, input int ec, input logic ee);
    return mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, ep, ec, ee);
  endfunction

  task automatic drive_idle();
    alloc_req = 1'b0; commit_valid = 1'b0; release_valid = 1'b0;
    release_preg = '0; flush = 1'b0;
  endtask

  task automatic run_vecs(input string name);
    vec_t e;
    phase = name;
    for (int i = 0; i < vecs.size(); i++) begin
      alloc_req     = vecs[i].alloc_req;
      commit_valid  = vecs[i].commit_valid;
      release_valid = vecs[i].release_valid;
      release_preg  = vecs[i].release_preg;
      flush         = vecs[i].flush;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d alloc_valid", i), 32'(alloc_valid), 32'(e.exp_valid));
      if (e.exp_valid)
        check($sformatf("v%0d alloc_preg", i), 32'(alloc_preg), 32'(e.exp_preg));
      check($sformatf("v%0d free_count", i), 32'(free_count), 32'(e.exp_count));
      check($sformatf("v%0d err_overflow", i), 32'(err_overflow), 32'(e.exp_err));
      @(posedge clk);
      #1;
    end
    vecs.delete();
    drive_idle();
  endtask

  task automatic check_reset_outputs(input string name);
    phase = name;
    check("reset alloc_valid", 32'(alloc_valid), 32'd1);
    check("reset alloc_preg", 32'(alloc_preg), 32'd32);
    check("reset free_count", 32'(free_count), 32'd32);
    check("reset err_overflow", 32'(err_overflow), 32'd0);
  endtask

  task automatic do_reset(input string name);
    drive_idle();
    rst_n = 1'b0;
    #3;
    check_reset_outputs(name);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b1;
    #2;

    // T1: drain the full list in order.
    do_reset("T1");
    for (int k = 0; k < 32; k++) vecs.push_back(alloc(32 + k, 32 - k, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0));
    vecs.push_back(idle(1'b0, 0, 0, 1'b0));
    run_vecs("T1");

    // T2: release into an empty list, then alloc+release while non-empty.
`ifdef FREE_LIST_BYPASS_EN
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b1, 40, 0, 1'b0));
    vecs.push_back(idle(1'b0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 41, 1'b0, 1'b1, 41, 0, 1'b0));
`else
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b0, 0, 0, 1'b0));
    vecs.push_back(idle(1'b1, 40, 1, 1'b0));
    vecs.push_back(alloc(40, 1, 1'b0));
    vecs.push_back(idle(1'b0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 41, 1'b0, 1'b0, 0, 0, 1'b0));
`endif
    vecs.push_back(idle(1'b1, 41, 1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 42, 1'b0, 1'b1, 41, 1, 1'b0));
    vecs.push_back(idle(1'b1, 42, 1, 1'b0));
    run_vecs("T2");

    // T3: three allocs, one commit, flush back to committed head.
    do_reset("T3");
    vecs.push_back(alloc(32, 32, 1'b0));
    vecs.push_back(alloc(33, 31, 1'b0));
    vecs.push_back(alloc(34, 30, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 35, 29, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 35, 29, 1'b0));
    vecs.push_back(idle(1'b1, 33, 31, 1'b0));
    run_vecs("T3");

    // T4: flush with same-cycle commit, then flush with release and ignored alloc.
    vecs.push_back(alloc(33, 31, 1'b0));
    vecs.push_back(alloc(34, 30, 1'b0));
    vecs.push_back(alloc(35, 29, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 36, 28, 1'b0));
    vecs.push_back(idle(1'b1, 34, 30, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 33, 1'b1, 1'b1, 34, 30, 1'b0));
    vecs.push_back(idle(1'b1, 34, 31, 1'b0));
    run_vecs("T4");

    // T5: release into a full list sets the sticky error.
    do_reset("T5");
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 50, 1'b0, 1'b1, 32, 32, 1'b0));
    vecs.push_back(idle(1'b1, 32, 32, 1'b1));
    vecs.push_back(idle(1'b1, 32, 32, 1'b1));
    vecs.push_back(alloc(32, 32, 1'b1));
    vecs.push_back(idle(1'b1, 33, 31, 1'b1));
    run_vecs("T5");

    // T5b: commit with nothing allocated is an error and is ignored.
    do_reset("T5b");
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32, 32, 1'b0));
    vecs.push_back(idle(1'b1, 32, 32, 1'b1));
    // T6: r0 release is dropped.
    vecs.push_back(alloc(32, 32, 1'b1));
    vecs.push_back(alloc(33, 31, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 34, 30, 1'b1));
    vecs.push_back(idle(1'b1, 34, 30, 1'b1));
    run_vecs("T6");

    // T6: reset mid-burst clears state without a clock edge.
    phase = "T6 burst";
    alloc_req = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("burst free_count", 32'(free_count), 32'd27);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("T6 async");
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vecs.push_back(idle(1'b1, 32, 32, 1'b0));
    run_vecs("T6 post");

    phase = "end";
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
